// File: rtl/iomem_initiator.sv
// iomem_initiator: turns one core load/store request into a single iomem
// valid/ready transaction, with lane steering, strobe generation, load
// extension, misalignment rejection and a bus timeout.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   req_valid_i / req_ready_o    core request handshake (ready only in IDLE)
//   req_addr_i, req_we_i         byte address, 1 = store
//   req_size_i                   00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned_i               load zero-extend (1) / sign-extend (0)
//   req_wdata_i                  right-aligned store data
//   rsp_valid_o                  one-cycle response pulse
//   rsp_rdata_o, rsp_err_o       extended load data, error flag
//   iomem_valid_o/iomem_ready_i  bus handshake
//   iomem_wstrb_o                byte strobes, 0000 = read
//   iomem_addr_o                 word-aligned bus address
//   iomem_wdata_o                lane-replicated store data
//   iomem_rdata_i                bus read data, valid with iomem_ready_i
module iomem_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        iomem_valid_o,
    input  logic        iomem_ready_i,
    output logic [3:0]  iomem_wstrb_o,
    output logic [31:0] iomem_addr_o,
    output logic [31:0] iomem_wdata_o,
    input  logic [31:0] iomem_rdata_i
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    logic [1:0]       state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             req_ready_q, req_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_err_q,   rsp_err_d;
    logic [31:0]      rsp_rdata_q, rsp_rdata_d;
    logic             bus_valid_q, bus_valid_d;
    logic [3:0]       wstrb_q,     wstrb_d;
    logic [31:0]      addr_q,      addr_d;
    logic [31:0]      wdata_q,     wdata_d;
    logic [1:0]       off_q,       off_d;
    logic [1:0]       size_q,      size_d;
    logic             uns_q,       uns_d;
    logic             we_q,        we_d;

    logic             req_illegal_c;
    logic [3:0]       req_wstrb_c;
    logic [31:0]      req_wdata_c;
    logic [31:0]      load_ext_c;
    logic [7:0]       load_byte_c;
    logic [15:0]      load_half_c;

    // Request decode: legality, strobes and lane-replicated store data
    always_comb begin
        req_illegal_c = 1'b0;
        req_wstrb_c   = 4'b0000;
        req_wdata_c   = req_wdata_i;
        case (req_size_i)
            SZ_BYTE: begin
                req_wstrb_c = 4'b0001 << req_addr_i[1:0];
                req_wdata_c = {4{req_wdata_i[7:0]}};
            end
            SZ_HALF: begin
                req_illegal_c = req_addr_i[0];
                req_wstrb_c   = req_addr_i[1] ? 4'b1100 : 4'b0011;
                req_wdata_c   = {2{req_wdata_i[15:0]}};
            end
            SZ_WORD: begin
                req_illegal_c = |req_addr_i[1:0];
                req_wstrb_c   = 4'b1111;
            end
            default: req_illegal_c = 1'b1;
        endcase
        if (!req_we_i) begin
            req_wstrb_c = 4'b0000;
        end
    end

    // Load lane select and extension from the registered offset/size
    always_comb begin
        case (off_q)
            2'd0:    load_byte_c = iomem_rdata_i[7:0];
            2'd1:    load_byte_c = iomem_rdata_i[15:8];
            2'd2:    load_byte_c = iomem_rdata_i[23:16];
            default: load_byte_c = iomem_rdata_i[31:24];
        endcase
        load_half_c = off_q[1] ? iomem_rdata_i[31:16] : iomem_rdata_i[15:0];
        case (size_q)
            SZ_BYTE: load_ext_c = uns_q ? {24'd0, load_byte_c}
                                        : {{24{load_byte_c[7]}}, load_byte_c};
            SZ_HALF: load_ext_c = uns_q ? {16'd0, load_half_c}
                                        : {{16{load_half_c[15]}}, load_half_c};
            default: load_ext_c = iomem_rdata_i;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 32'd0;
        wstrb_d     = wstrb_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        off_d       = off_q;
        size_d      = size_q;
        uns_d       = uns_q;
        we_d        = we_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    if (req_illegal_c) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d = ST_BUS;
                        cnt_d   = '0;
                        wstrb_d = req_wstrb_c;
                        addr_d  = {req_addr_i[31:2], 2'b00};
                        wdata_d = req_wdata_c;
                        off_d   = req_addr_i[1:0];
                        size_d  = req_size_i;
                        uns_d   = req_unsigned_i;
                        we_d    = req_we_i;
                    end
                end
            end
            ST_BUS: begin
                // A ready in the final counted cycle still completes normally
                if (iomem_ready_i) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = we_q ? 32'd0 : load_ext_c;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        bus_valid_d = (state_d == ST_BUS);
        req_ready_d = (state_d == ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
            bus_valid_q <= 1'b0;
            wstrb_q     <= 4'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            off_q       <= 2'd0;
            size_q      <= 2'd0;
            uns_q       <= 1'b0;
            we_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            bus_valid_q <= bus_valid_d;
            wstrb_q     <= wstrb_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            off_q       <= off_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            we_q        <= we_d;
        end
    end

    assign req_ready_o   = req_ready_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_err_o     = rsp_err_q;
    assign rsp_rdata_o   = rsp_rdata_q;
    assign iomem_valid_o = bus_valid_q;
    assign iomem_wstrb_o = wstrb_q;
    assign iomem_addr_o  = addr_q;
    assign iomem_wdata_o = wdata_q;

endmodule

// File: doc/iomem_initiator.md
# iomem_initiator

Bus initiator that turns a core-side load/store request into a single iomem valid/ready transaction. It sits between the processor's load/store unit and the iomem bus that serves main RAM, the timer and peripherals. It handles byte/halfword lane steering, write-strobe generation, load sign/zero extension, misalignment rejection and a bus timeout. One transaction is outstanding at a time.

## Interface
- TIMEOUT_CYCLES, 1024: cycles `iomem_valid_o` may stay high without `iomem_ready_i` before the access is aborted with an error; must be ≥2.

Clock and reset: one clock; reset is synchronous and active-high.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge
- rst_i  in  1  synchronous, active-high reset
- req_valid_i  in  1  core request valid
- req_ready_o  out  1  initiator can accept a request (high only in IDLE)
- req_addr_i  in  32  byte address
- req_we_i  in  1  1 = store, 0 = load
- req_size_i  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_unsigned_i  in  1  load zero-extends when 1, sign-extends when 0
- req_wdata_i  in  32  store data, right-aligned
- rsp_valid_o  out  1  one-cycle response pulse
- rsp_rdata_o  out  32  extended load data; 0 for stores and errors
- rsp_err_o  out  1  misaligned/illegal request or timeout; valid with rsp_valid_o
- iomem_valid_o  out  1  bus request valid
- iomem_ready_i  in  1  bus responder ready
- iomem_wstrb_o  out  4  byte strobes; 0000 = read
- iomem_addr_o  out  32  word-aligned address `{req_addr_i[31:2],2'b00}`
- iomem_wdata_o  out  32  lane-replicated store data
- iomem_rdata_i  in  32  read data; valid while iomem_ready_i is high

## Operation
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - `req_ready_o` = 1.
  - On `req_valid_i` with the request illegal (size 11, half with addr[0]=1, or word with addr[1:0]≠0) → RESP with err=1. No bus cycle is issued.
  - On `req_valid_i` with a legal request → register addr/strobe/data → BUS.
- Strobes (stores): byte → 1<<addr[1:0]; half → 0011 (addr[1]=0) or 1100; word → 1111. Loads → 0000.
- Write data: byte → {4{wdata[7:0]}}; half → {2{wdata[15:0]}}; word as is.
- BUS:
  - `iomem_valid_o` = 1; addr/wstrb/wdata held stable.
  - Timeout counter starts at 0 and increments each cycle.
  - On `iomem_ready_i`: select lane by registered addr[1:0] and size, extend per req_unsigned, register as rsp data, err=0 → RESP.
  - If the counter reaches TIMEOUT_CYCLES-1 without ready → RESP with err=1, data 0.
- RESP: `rsp_valid_o` = 1 for exactly one cycle, with no backpressure → IDLE.
- `iomem_ready_i` is ignored outside BUS; a late ready after a timeout has no effect.
- Store responses return `rsp_rdata_o` = 0.

## Timing
- Reset values: state IDLE; `req_ready_o`=1; `rsp_valid_o`=0; `rsp_err_o`=0; `rsp_rdata_o`=0; `iomem_valid_o`=0; `iomem_wstrb_o`=0; `iomem_addr_o`=0; `iomem_wdata_o`=0; timeout counter 0.
- Reset asserted mid-BUS drops `iomem_valid_o` at the next edge and produces no response.
- Accept at edge E0 → `iomem_valid_o` high from cycle E0+1.
- Ready sampled high at edge Ek → `iomem_valid_o` low in the following cycle, `rsp_valid_o` high that same cycle, `req_ready_o` high one cycle later.
- Zero-wait responder (ready in the first valid cycle): request-to-response is 2 cycles; peak throughput is one access per 3 cycles.
- Illegal request: `rsp_valid_o` with err in the cycle after acceptance; `iomem_valid_o` never rises.
- Timeout: `iomem_valid_o` high for exactly TIMEOUT_CYCLES cycles, then `rsp_valid_o` with err.
- Outputs are registered; there is no combinational path from `iomem_ready_i` to any output.
- Because `iomem_valid_o` deasserts the cycle after ready, a multi-cycle ready pulse from a shift-register responder is never double-counted.

## Test plan
- Word load at 0x4000_0010, ready after 16 valid cycles with rdata 0xDEAD_BEEF → wstrb 0000, addr 0x4000_0010, valid high exactly 16 cycles, rsp_rdata 0xDEAD_BEEF, err 0.
- Byte store 0xAB at 0x4000_0003 → wstrb 1000, wdata 0xABAB_ABAB, addr 0x4000_0000; rsp_rdata 0.
- Halfword load at 0x4000_0006, rdata 0x8001_1234: signed → 0xFFFF_8001; unsigned → 0x0000_8001. Byte load at offset 0 unsigned → 0x0000_0034.
- Word load at 0x4000_0002 and size 11 → err 1 one cycle after accept, iomem_valid_o stays 0.
- TIMEOUT_CYCLES=8, ready never asserted → valid high for 8 cycles, then rsp err 1 with data 0; a subsequent ready pulse is ignored and the next request proceeds normally.
- Zero-wait read of 0x3000_0000 (ready combinational with valid) → response 2 cycles after accept. Separately, assert rst_i mid-BUS → valid low next cycle, no rsp_valid, IDLE with req_ready_o=1.
